// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stalls, data-memory wait freeze,
// taken-branch flushes, forwarding suppression for EX bubbles and a stall counter.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze,
  output logic             ignore_fwd_ex,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WC_W-1:0]   r_wait_cnt;
  logic [WC_W-1:0]   w_wait_cnt_nxt;
  logic              r_ignore_fwd_ex;
  logic              r_mem_timeout;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic              w_load_use;
  logic              w_mem_wait;
  logic              w_hold_wait;
  logic              w_timeout_set;

  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign w_mem_wait = mem_req && !mem_ack;

  // Next-state and control decode; priority is memory wait, then branch, then load-use.
  always_comb begin
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    bubble_ex      = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    freeze         = 1'b0;
    w_timeout_set  = 1'b0;
    w_hold_wait    = 1'b0;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;

    case (r_state)
      ST_MEM_WAIT: w_hold_wait = !mem_ack;
      ST_RUN:      w_hold_wait = 1'b0;
      default:     w_hold_wait = 1'b0;
    endcase

    if (!rst_n) begin
      w_state_nxt    = ST_RUN;
      w_wait_cnt_nxt = {WC_W{1'b0}};
    end else if (w_hold_wait) begin
      freeze      = 1'b1;
      w_state_nxt = ST_MEM_WAIT;
      if (r_wait_cnt == WC_W'(TIMEOUT)) begin
        w_timeout_set = 1'b1;
      end else begin
        w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
      end
    end else if (w_mem_wait) begin
      freeze         = 1'b1;
      w_state_nxt    = ST_MEM_WAIT;
      w_wait_cnt_nxt = WC_W'(1);
    end else if (ex_branch_taken) begin
      // The ID instruction is squashed, so a pending load-use on it is irrelevant.
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      w_state_nxt = ST_RUN;
    end else if (w_load_use) begin
      stall_if    = 1'b1;
      stall_id    = 1'b1;
      bubble_ex   = 1'b1;
      w_state_nxt = ST_RUN;
    end else begin
      w_state_nxt = ST_RUN;
    end
  end

  // State, wait counter, sticky timeout, forwarding-suppress flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_RUN;
      r_wait_cnt      <= {WC_W{1'b0}};
      r_ignore_fwd_ex <= 1'b0;
      r_mem_timeout   <= 1'b0;
      r_stall_cycles  <= {CNT_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_timeout_set) begin
        r_mem_timeout <= 1'b1;
      end
      if (!freeze) begin
        r_ignore_fwd_ex <= bubble_ex || flush_id_ex;
      end
      if ((stall_if || freeze) && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

  assign ignore_fwd_ex = r_ignore_fwd_ex;
  assign mem_timeout   = r_mem_timeout;
  assign stall_cycles  = r_stall_cycles;

endmodule
